// File: rtl/axi_lite_mem_master.sv
// axi_lite_mem_master: bridges a simple single-request core memory port onto
// an AXI4-Lite master with at most one transaction outstanding. Reads issue
// AR then wait for R; writes issue AW and W together, then wait for B.
// Build option MISALIGN_CHECK_EN: when defined, requests whose address is not
// word aligned get an immediate error response and never reach the bus.
module axi_lite_mem_master (
  input  logic        clk,
  input  logic        rstn,
  // core request / response
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  // AXI4-Lite read channels
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [2:0]  m_arprot,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  // AXI4-Lite write channels
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [2:0]  m_awprot,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready
);

  typedef enum logic [2:0] {IDLE, AR, R, W, B} state_t;

  state_t      state, state_next;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_done;      // AW handshake already taken in this write
  logic        w_done;       // W handshake already taken in this write
  logic        run_q;        // low during reset and until the first clock after it
  logic        accept;
  logic        misaligned;
  logic        aw_hs;
  logic        w_hs;
  logic        aw_fin;
  logic        w_fin;
  logic        unused_resp_lsb;

  // Only the SLVERR/DECERR bit of the responses matters to the core.
  assign unused_resp_lsb = ^{m_rresp[0], m_bresp[0]};

  assign req_ready = run_q && (state == IDLE);
  assign accept    = req_valid && req_ready;

`ifdef MISALIGN_CHECK_EN
  assign misaligned = (req_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Channel outputs are pure decodes of state and latched payload, so they
  // cannot change while a valid waits for its ready.
  assign m_arvalid = (state == AR);
  assign m_araddr  = addr_q;
  assign m_arprot  = 3'b000;
  assign m_rready  = (state == R);
  assign m_awvalid = (state == W) && !aw_done;
  assign m_wvalid  = (state == W) && !w_done;
  assign m_awaddr  = addr_q;
  assign m_awprot  = 3'b000;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_bready  = (state == B);

  assign aw_hs  = m_awvalid && m_awready;
  assign w_hs   = m_wvalid && m_wready;
  assign aw_fin = aw_done || aw_hs;
  assign w_fin  = w_done || w_hs;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assigned first so no branch leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    case (state)
      IDLE:    if (accept && !misaligned) state_next = req_we ? W : AR;
      AR:      if (m_arready)             state_next = R;
      R:       if (m_rvalid)              state_next = IDLE;
      W:       if (aw_fin && w_fin)       state_next = B;
      B:       if (m_bvalid)              state_next = IDLE;
      default:                            state_next = IDLE;
    endcase
  end

  // Request latch, write-channel progress flags and the registered response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      resp_valid <= 1'b0;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (state == W) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (accept && misaligned) begin
        resp_valid <= 1'b1;
        resp_data  <= '0;
        resp_err   <= 1'b1;
      end
      if ((state == R) && m_rvalid) begin
        resp_valid <= 1'b1;
        resp_data  <= m_rdata;
        resp_err   <= m_rresp[1];
      end
      if ((state == B) && m_bvalid) begin
        resp_valid <= 1'b1;
        resp_data  <= '0;
        resp_err   <= m_bresp[1];
      end
    end
  end

endmodule

// File: doc/axi_lite_mem_master.md
AXI_LITE_MEM_MASTER -- requirements
Module: axi_lite_mem_master
Interface (no parameters; ports: name  direction  width  meaning)
REQ-001 clk  in  1  single clock; all state updates on the rising edge.
REQ-002 rstn  in  1  reset, asynchronous assert, active-low.
REQ-003 req_valid  in  1  core memory request present.
REQ-004 req_ready  out  1  block can accept a request.
REQ-005 req_we  in  1  1 = write, 0 = read.
REQ-006 req_addr  in  32  byte address.
REQ-007 req_wdata  in  32  write data.
REQ-008 req_wstrb  in  4  write byte enables.
REQ-009 resp_valid  out  1  one-cycle completion pulse.
REQ-010 resp_data  out  32  read data (0 for writes).
REQ-011 resp_err  out  1  bus or alignment error.
REQ-012 m_araddr  out  32  AXI4-Lite read address.
REQ-013 m_arvalid  out  1  read address valid.
REQ-014 m_arready  in  1  read address ready.
REQ-015 m_arprot  out  3  read protection, constant 3'b000.
REQ-016 m_rdata  in  32  read data.
REQ-017 m_rresp  in  2  read response.
REQ-018 m_rvalid  in  1  read data valid.
REQ-019 m_rready  out  1  read data ready.
REQ-020 m_awaddr  out  32  write address.
REQ-021 m_awvalid  out  1  write address valid.
REQ-022 m_awready  in  1  write address ready.
REQ-023 m_awprot  out  3  write protection, constant 3'b000.
REQ-024 m_wdata  out  32  write data.
REQ-025 m_wstrb  out  4  write strobes.
REQ-026 m_wvalid  out  1  write data valid.
REQ-027 m_wready  in  1  write data ready.
REQ-028 m_bresp  in  2  write response.
REQ-029 m_bvalid  in  1  write response valid.
REQ-030 m_bready  out  1  write response ready.
Function
REQ-031 States: IDLE, AR, R, W, B. Only one transaction is outstanding at a time.
REQ-032 req_ready SHALL be 1 only in IDLE; on req_valid&&req_ready, latch addr/wdata/wstrb/we and go to AR (read) or W (write).
REQ-033 AR: m_arvalid=1 and m_araddr=latched addr; both held stable until m_arready; on handshake go to R.
REQ-034 R: m_rready=1; on m_rvalid, register resp_data=m_rdata and resp_err=m_rresp[1], pulse resp_valid next cycle, go to IDLE.
REQ-035 W: m_awvalid and m_wvalid both assert on entry; each drops independently after its own handshake; go to B once both have completed, including both in the same cycle.
REQ-036 B: m_bready=1; on m_bvalid, pulse resp_valid with resp_data=0 and resp_err=m_bresp[1], go to IDLE.
REQ-037 A valid SHALL never drop before its handshake; payloads SHALL stay constant while the valid is high; m_rready and m_bready SHALL be 0 outside R and B.
REQ-038 Zero-wait read latency: accept in cycle 0 -> m_arvalid in cycle 1 -> resp_valid in cycle 3; req_ready=1 again in the resp_valid cycle.
REQ-039 resp_valid SHALL be high for exactly one cycle; resp_data and resp_err SHALL hold their values until the next response.
REQ-040 m_wdata and m_wstrb SHALL equal the latched values; m_araddr and m_awaddr SHALL carry the full 32-bit latched address, unmodified.
Reset
REQ-041 While rstn=0: state=IDLE and all outputs=0, including req_ready; an in-flight transaction is abandoned without a response; req_ready=1 on the first clock after rstn rises.
Configuration
REQ-042 With MISALIGN_CHECK_EN defined: an accepted request with req_addr[1:0]!=0 issues no AXI transaction; resp_valid=1, resp_err=1, resp_data=0 in cycle 1; then return to IDLE.
REQ-043 With MISALIGN_CHECK_EN undefined: alignment is not checked; such addresses pass to m_araddr/m_awaddr unchanged.
Verification
REQ-044 Read 0x80000010, slave arready=1, rvalid next cycle with rdata=0xDEADBEEF, rresp=0 -> arvalid in cycle 1, resp_valid in cycle 3, data 0xDEADBEEF, err 0.
REQ-045 Write 0x1000/0x12345678/wstrb 0xF, awready at once, wready 3 cycles later -> awvalid drops after 1 cycle, wvalid held 4 cycles, bready only after both, err 0.
REQ-046 Write with bresp=2'b10 -> resp_valid with resp_err=1 and resp_data=0.
REQ-047 Read 0x1002 -> with macro: no arvalid, err pulse in cycle 1; without macro: m_araddr=0x1002.
REQ-048 rstn low while in R with rvalid pending -> all outputs 0 immediately, no resp_valid; after release, next read completes normally.
